// File: rtl/rv32i_types.sv
// rv32i_types: shared responder state encoding and byte-merge helper.
package rv32i_types;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dmem_state_t;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] new_word, input logic [3:0] be);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i+:8] = be[i] ? new_word[8*i+:8] : old_word[8*i+:8];
    return w;
  endfunction
endpackage

// File: rtl/dmem_word_buffer.sv
// dmem_word_buffer: one-entry read buffer with full-word load and byte-merge on write.
module dmem_word_buffer
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_tag,
  output logic        hit,
  output logic [31:0] data,
  input  logic        load,
  input  logic        merge,
  input  logic [29:0] wr_tag,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be
);
  logic        valid;
  logic [29:0] tag;
  assign hit = valid && tag == lookup_tag;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end else if (merge && valid && tag == wr_tag) begin
      data <= merge_bytes(data, wr_data, wr_be);
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with one-word read buffer and pmem timeout.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int PMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
);
  localparam int CW = PMEM_TIMEOUT > 1 ? $clog2(PMEM_TIMEOUT) : 1;
  dmem_state_t state, state_d;
  logic [29:0]   tag_q;
  logic [31:0]   wdata_q, rdata_q, rdata_d, buf_data;
  logic [3:0]    be_q;
  logic [CW-1:0] cnt;
  logic          hit, rdata_en, load, merge, busy, timeout, addr_unused;
  assign addr_unused = ^mem_address[1:0];
  assign busy = state == READ || state == WRITE;
  assign timeout = cnt == CW'(PMEM_TIMEOUT - 1);
  dmem_word_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (mem_address[31:2]),
    .hit        (hit),
    .data       (buf_data),
    .load       (load),
    .merge      (merge),
    .wr_tag     (tag_q),
    .wr_data    (load ? pmem_rdata : wdata_q),
    .wr_be      (be_q)
  );
  always_comb begin
    state_d  = state;
    rdata_en = 1'b0;
    rdata_d  = '0;
    load     = 1'b0;
    merge    = 1'b0;
    case (state)
      IDLE: if (mem_write) begin
        state_d  = |mem_byte_enable ? WRITE : DONE;
        rdata_en = ~|mem_byte_enable;
      end else if (mem_read) begin
        state_d  = hit ? DONE : READ;
        rdata_en = hit;
        rdata_d  = buf_data;
      end
      READ, WRITE: if (pmem_resp || timeout) begin
        state_d  = DONE;
        rdata_en = 1'b1;
        rdata_d  = pmem_resp ? (state == READ ? pmem_rdata : '0) : TIMEOUT_RDATA;
        load     = pmem_resp && state == READ;
        merge    = pmem_resp && state == WRITE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= busy && state_d == state ? cnt + CW'(1) : '0;
      if (state == IDLE && state_d != IDLE) begin
        tag_q   <= mem_address[31:2];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
      end
      if (rdata_en) rdata_q <= rdata_d;
    end
  end
  // Outputs are gated by rst so nothing leaks out during the reset cycle itself.
  assign mem_resp         = !rst && state == DONE;
  assign mem_rdata        = rst ? '0 : rdata_q;
  assign pmem_read        = !rst && state == READ;
  assign pmem_write       = !rst && state == WRITE;
  assign pmem_address     = !rst && busy ? {tag_q, 2'b00} : '0;
  assign pmem_wdata       = pmem_write ? wdata_q : '0;
  assign pmem_byte_enable = pmem_write ? be_q : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table plus randomized requests against a word-buffer model.
module tb_dmem_responder;
  localparam int TMO = 255;
  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [3:0]  mem_byte_enable, pmem_byte_enable;
  logic [31:0] mem_address, mem_wdata, mem_rdata, pmem_address, pmem_wdata, pmem_rdata;
  int n_checks = 0, n_fail = 0;
  logic        m_valid;
  logic [29:0] m_tag;
  logic [31:0] m_data;

  typedef struct {
    logic        rd, wr;
    logic [3:0]  be;
    logic [31:0] addr, wd;
    int          delay;
    logic [31:0] prdata, exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t tab[13];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_resp         (mem_resp),
    .mem_rdata        (mem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_resp        (pmem_resp),
    .pmem_rdata       (pmem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // pmem_resp is pulsed in cycle `delay` after the sample cycle; delay 0 means never.
  task automatic run_req(input string name, input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd, input int delay,
                         input logic [31:0] prdata, input logic use_tab,
                         input logic [31:0] tab_rdata, input int tab_lat);
    int kind, lat, resp_cyc = 0, pulses = 0, bus_errs = 0, lat_exp;
    logic hitm, tmo, e_rd, e_wr;
    logic [31:0] rdata_exp, got = '0;
    hitm = m_valid && m_tag == addr[31:2];
    kind = wr ? (be != 4'h0 ? 2 : 0) : (hitm ? 0 : 1);
    tmo = kind != 0 && (delay == 0 || delay > TMO);
    lat = kind == 0 ? 1 : (tmo ? TMO + 1 : delay + 1);
    rdata_exp = tmo ? 32'hDEADBEEF : (wr ? 32'h0 : (hitm ? m_data : prdata));
    lat_exp = lat;
    if (use_tab) begin
      lat_exp = tab_lat;
      rdata_exp = tab_rdata;
    end
    mem_read = rd;
    mem_write = wr;
    mem_byte_enable = be;
    mem_address = addr;
    mem_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      e_rd = kind == 1 && c < lat;
      e_wr = kind == 2 && c < lat;
      if (pmem_read !== e_rd || pmem_write !== e_wr ||
          pmem_address !== ((e_rd || e_wr) ? {addr[31:2], 2'b00} : 32'h0) ||
          pmem_byte_enable !== (e_wr ? be : 4'h0) || pmem_wdata !== (e_wr ? wd : 32'h0))
        bus_errs++;
      if (mem_resp === 1'b1) begin
        pulses++;
        if (resp_cyc == 0) begin
          resp_cyc = c;
          got = mem_rdata;
        end
      end
      if (c == lat + 1) check({name, " hold"}, mem_rdata, rdata_exp);
      pmem_resp = delay != 0 && c == delay;
      pmem_rdata = pmem_resp ? prdata : $urandom;
      mem_read = c < lat ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_write = c < lat ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_byte_enable = c < lat ? 4'($urandom_range(0, 15)) : 4'h0;
      mem_address = c < lat ? $urandom : 32'h0;
      mem_wdata = c < lat ? $urandom : 32'h0;
    end
    check({name, " lat"}, resp_cyc, lat_exp);
    check({name, " rdata"}, got, rdata_exp);
    check({name, " pulses"}, pulses, 1);
    check({name, " bus"}, bus_errs, 0);
    if (!tmo && kind == 1) begin
      m_valid = 1'b1;
      m_tag = addr[31:2];
      m_data = prdata;
    end else if (!tmo && kind == 2 && hitm) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_data[8*i+:8] = wd[8*i+:8];
    end
  endtask

  initial begin
    logic [31:0] bases[4];
    int op, pulses;
    bases = '{32'h100, 32'h104, 32'h200, 32'h300};
    tab[0]  = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        3, 32'h12345678, 32'h12345678, 4};
    tab[1]  = '{1'b1, 1'b0, 4'h0, 32'h102, 32'h0,        1, 32'h0,        32'h12345678, 1};
    tab[2]  = '{1'b0, 1'b1, 4'h3, 32'h100, 32'hAAAABBBB, 2, 32'h0,        32'h0,        3};
    tab[3]  = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        0, 32'h0,        32'h1234BBBB, 1};
    tab[4]  = '{1'b1, 1'b1, 4'hF, 32'h200, 32'h55,       1, 32'h0,        32'h0,        2};
    tab[5]  = '{1'b0, 1'b1, 4'h0, 32'h300, 32'h99,       0, 32'h0,        32'h0,        1};
    tab[6]  = '{1'b1, 1'b0, 4'h0, 32'h400, 32'h0,        0, 32'h0,        32'hDEADBEEF, TMO + 1};
    tab[7]  = '{1'b1, 1'b0, 4'h0, 32'h400, 32'h0,        2, 32'h0BADF00D, 32'h0BADF00D, 3};
    tab[8]  = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        2, 32'h11112222, 32'h11112222, 3};
    tab[9]  = '{1'b0, 1'b1, 4'hC, 32'h100, 32'hCCDD0000, 1, 32'h0,        32'h0,        2};
    tab[10] = '{1'b1, 1'b0, 4'h0, 32'h103, 32'h0,        0, 32'h0,        32'hCCDD2222, 1};
    tab[11] = '{1'b0, 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF, 0, 32'h0,        32'hDEADBEEF, TMO + 1};
    tab[12] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        0, 32'h0,        32'hCCDD2222, 1};
    rst = 1'b1;
    {mem_read, mem_write, pmem_resp} = '0;
    mem_byte_enable = '0;
    {mem_address, mem_wdata, pmem_rdata} = '0;
    {m_valid, m_tag, m_data} = '0;
    repeat (3) @(negedge clk);
    check("reset mem_resp", mem_resp, 0);
    check("reset mem_rdata", mem_rdata, 0);
    check("reset pmem_read", pmem_read, 0);
    check("reset pmem_write", pmem_write, 0);
    check("reset pmem_address", pmem_address, 0);
    check("reset pmem_wdata", pmem_wdata, 0);
    check("reset pmem_be", pmem_byte_enable, 0);
    rst = 1'b0;
    foreach (tab[i])
      run_req($sformatf("vec%0d", i), tab[i].rd, tab[i].wr, tab[i].be, tab[i].addr, tab[i].wd,
              tab[i].delay, tab[i].prdata, 1'b1, tab[i].exp_rdata, tab[i].exp_lat);
    mem_read = 1'b1;
    mem_address = 32'h500;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    mem_address = '0;
    check("rst_mid pmem_read before", pmem_read, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid pmem_read after", pmem_read, 0);
    check("rst_mid pmem_address after", pmem_address, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_resp === 1'b1 || pmem_read === 1'b1) pulses++;
    end
    check("rst_mid no activity", pulses, 0);
    {m_valid, m_tag, m_data} = '0;
    run_req("rst_mid miss", 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2, 32'h00000077, 1'b1, 32'h00000077, 3);
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      run_req("rnd", op != 2, op >= 2, 4'($urandom_range(0, 15)),
              bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 19) == 0 ? 0 : $urandom_range(1, 5), $urandom, 1'b0, 32'h0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
